// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL host-side write path.
// Holds the default chip recovery times and the write sequencer state encoding.
package jtopl_pkg;

  // Default recovery times, counted in chip cen ticks
  localparam int unsigned ADDR_WAIT_DEF = 12;
  localparam int unsigned DATA_WAIT_DEF = 84;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AWAIT,
    S_DATA,
    S_DWAIT
  } wr_state_t;

endpackage

// File: rtl/jtopl_wrfifo.sv
// Small synchronous FIFO built from plain registers.
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   push, din       write an entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   rd_data         current head entry
//   full, empty     occupancy flags
//   level           number of stored entries
module jtopl_wrfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jtopl_wrseq.sv
// Host-side write sequencer for the OPL core.
// Buffers (register, value) commands and replays each as an address-port write
// followed by a data-port write, honouring the chip recovery times in cen ticks.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   cen                   chip clock enable shared with the OPL core
//   cmd_valid/cmd_ready   command handshake (ready = FIFO not full)
//   cmd_reg, cmd_val      register number and value
//   write, addr, dout     one-clk chip write strobe, port select, bus data
//   busy                  work pending or in progress
//   level                 FIFO occupancy
module jtopl_wrseq
  import jtopl_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_WAIT = ADDR_WAIT_DEF,
  parameter int unsigned DATA_WAIT = DATA_WAIT_DEF,
  parameter bit          SKIP_SAME = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_reg,
  input  logic [7:0]             cmd_val,
  output logic                   write,
  output logic                   addr,
  output logic [7:0]             dout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  wr_state_t   state;
  logic [7:0]  cnt;
  logic [7:0]  cur_reg;
  logic [7:0]  cur_val;
  logic [7:0]  last_reg;
  logic        last_valid;
  logic [15:0] head;
  logic        full;
  logic        empty;
  logic        pop;

  assign cmd_ready = !full;
  assign pop       = (state == S_IDLE) && !empty;

  jtopl_wrfifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .din     ({cmd_reg, cmd_val}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // The strobe is registered in the ADDR/DATA states, so it appears one clk
  // after the state is entered. The counter is loaded on the strobe edge, so
  // a cen tick on that edge never counts toward the following wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur_reg    <= '0;
      cur_val    <= '0;
      last_reg   <= '0;
      last_valid <= 1'b0;
      write      <= 1'b0;
      addr       <= 1'b0;
      dout       <= '0;
      busy       <= 1'b0;
    end else begin
      write <= 1'b0;
      addr  <= 1'b0;
      dout  <= '0;
      busy  <= (state != S_IDLE) || !empty;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            cur_reg <= head[15:8];
            cur_val <= head[7:0];
            if (SKIP_SAME && last_valid && (head[15:8] == last_reg))
              state <= S_DATA;
            else
              state <= S_ADDR;
          end
        end
        S_ADDR: begin
          write      <= 1'b1;
          addr       <= 1'b0;
          dout       <= cur_reg;
          last_reg   <= cur_reg;
          last_valid <= 1'b1;
          cnt        <= 8'(ADDR_WAIT);
          state      <= S_AWAIT;
        end
        S_AWAIT: begin
          if (cen) begin
            if (cnt <= 8'd1) begin
              cnt   <= '0;
              state <= S_DATA;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        S_DATA: begin
          write <= 1'b1;
          addr  <= 1'b1;
          dout  <= cur_val;
          cnt   <= 8'(DATA_WAIT);
          state <= S_DWAIT;
        end
        S_DWAIT: begin
          if (cen) begin
            if (cnt <= 8'd1) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Testbench for jtopl_wrseq. Two instances run side by side on the same
// stimulus: index 0 omits repeated address writes, index 1 never does.
module tb_jtopl_wrseq;

  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int DW    = 84;
  localparam int LW    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_val = '0;

  logic          ready_s [2];
  logic          write_s [2];
  logic          addr_s  [2];
  logic [7:0]    dout_s  [2];
  logic          busy_s  [2];
  logic [LW-1:0] level_s [2];

  always #5 clk = ~clk;

  jtopl_wrseq #(.DEPTH(DEPTH), .ADDR_WAIT(AW), .DATA_WAIT(DW), .SKIP_SAME(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cmd_valid(cmd_valid), .cmd_ready(ready_s[0]),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val), .write(write_s[0]), .addr(addr_s[0]),
    .dout(dout_s[0]), .busy(busy_s[0]), .level(level_s[0])
  );

  jtopl_wrseq #(.DEPTH(DEPTH), .ADDR_WAIT(AW), .DATA_WAIT(DW), .SKIP_SAME(1'b0)) dut_noskip (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cmd_valid(cmd_valid), .cmd_ready(ready_s[1]),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val), .write(write_s[1]), .addr(addr_s[1]),
    .dout(dout_s[1]), .busy(busy_s[1]), .level(level_s[1])
  );

  int checks = 0;
  int failures = 0;

  // Free-running edge and cen-tick counters, read at negedges
  int   cyc = 0;
  int   ticks = 0;
  logic last_cen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ticks    <= ticks + int'(cen);
    last_cen <= cen;
  end

  // cen pattern: 0 = every clk, 1 = every 4th clk, 2 = random
  int cen_mode = 0;
  initial begin
    int phase = 0;
    forever begin
      @(negedge clk);
      phase++;
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = (phase % 4 == 0);
        default: cen = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: expected bus words {addr, dout} per instance
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [7:0] m_last  [2];
  bit         m_valid [2];
  int         prev_kind [2];
  int         prev_cyc  [2];
  int         prev_ticks[2];
  int         addr_count[2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void qpush(input int d, input logic [8:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic void modelPush(input logic [7:0] r, input logic [7:0] v);
    for (int d = 0; d < 2; d++) begin
      if (!((d == 0) && m_valid[d] && (m_last[d] == r)))
        qpush(d, {1'b0, r});
      qpush(d, {1'b1, v});
      m_last[d]  = r;
      m_valid[d] = 1'b1;
    end
  endfunction

  // Monitor: compares every strobe against the model and checks spacing
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (!write_s[d]) begin
          checkOutput($sformatf("d%0d_idle_bus", d), {23'd0, addr_s[d], dout_s[d]}, 32'd0);
        end else begin
          logic [8:0] exp;
          int qs;
          int gclk;
          int gticks;
          qs = (d == 0) ? exp_q0.size() : exp_q1.size();
          checkOutput($sformatf("d%0d_write_expected", d), 32'(qs > 0), 32'd1);
          if (qs > 0) begin
            exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("d%0d_bus_word", d), {23'd0, addr_s[d], dout_s[d]}, {23'd0, exp});
          end
          gclk   = cyc - prev_cyc[d];
          gticks = (ticks - int'(last_cen)) - prev_ticks[d];
          if (prev_kind[d] == 1) begin
            checkOutput($sformatf("d%0d_addr_wait_ticks", d), gticks, AW);
            checkOutput($sformatf("d%0d_addr_wait_clk_min", d), 32'(gclk >= AW + 1), 32'd1);
          end else if (prev_kind[d] == 2) begin
            checkOutput($sformatf("d%0d_data_wait_ticks_min", d), 32'(gticks >= DW), 32'd1);
            checkOutput($sformatf("d%0d_data_wait_clk_min", d), 32'(gclk >= DW + 2), 32'd1);
          end
          if (!addr_s[d]) addr_count[d]++;
          prev_kind[d]  = addr_s[d] ? 2 : 1;
          prev_cyc[d]   = cyc;
          prev_ticks[d] = ticks;
        end
      end
    end
  end

  // Called at a negedge; holds the command for exactly one rising edge
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] v);
    int waitc = 0;
    while (!(ready_s[0] && ready_s[1])) begin
      @(negedge clk);
      waitc++;
      if (waitc > 5000) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    cmd_reg   = r;
    cmd_val   = v;
    cmd_valid = 1'b1;
    modelPush(r, v);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_valid[d]    = 1'b0;
      prev_kind[d]  = 0;
      addr_count[d] = 0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_rst_bus", d), {22'd0, write_s[d], addr_s[d], dout_s[d]}, 32'd0);
      checkOutput($sformatf("d%0d_rst_busy", d), 32'(busy_s[d]), 32'd0);
      checkOutput($sformatf("d%0d_rst_level", d), 32'(level_s[d]), 32'd0);
      checkOutput($sformatf("d%0d_rst_ready", d), 32'(ready_s[d]), 32'd1);
    end
    rst_n = 1'b1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy_s[0] || busy_s[1] || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(n < 20000), 32'd1);
  endtask

  task automatic waitWrite(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write_s[0] && n < limit);
  endtask

  initial begin
    int n;
    @(negedge clk);
    doReset();

    // Single command with cen every clk
    cen_mode = 0;
    applyStimulus(8'h20, 8'h01);
    @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_single_pop_cycle", d), 32'(write_s[d]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("d%0d_single_addr", d), {22'd0, write_s[d], addr_s[d], dout_s[d]}, 32'h220);
    waitWrite(40, n);
    checkOutput("single_addr_to_data_gap", n, 13);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("d%0d_single_data", d), {22'd0, write_s[d], addr_s[d], dout_s[d]}, 32'h301);
    repeat (83) @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_busy_in_dwait", d), 32'(busy_s[d]), 32'd1);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_busy_after", d), 32'(busy_s[d]), 32'd0);
    waitIdle();

    // Repeated register: only instance 0 drops the second address write
    doReset();
    applyStimulus(8'hA0, 8'h44);
    applyStimulus(8'hA0, 8'h55);
    waitIdle();
    checkOutput("skip_addr_writes", addr_count[0], 1);
    checkOutput("noskip_addr_writes", addr_count[1], 2);

    // cen every 4th clk
    cen_mode = 1;
    applyStimulus(8'h40, 8'h3F);
    waitWrite(20, n);
    waitWrite(200, n);
    checkOutput("cen4_gap_in_range", 32'(n >= 46 && n <= 49), 32'd1);
    waitIdle();

    // FIFO fill behind a command in progress
    cen_mode = 0;
    doReset();
    applyStimulus(8'h10, 8'h01);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h11 + i), 8'(i));
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_full_ready", d), 32'(ready_s[d]), 32'd0);
      checkOutput($sformatf("d%0d_full_level", d), 32'(level_s[d]), 32'd4);
    end
    n = 0;
    while (!ready_s[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("full_ready_returns", 32'(ready_s[0]), 32'd1);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_level_first_pop", d), 32'(level_s[d]), 32'd3);
    applyStimulus(8'h15, 8'h05);
    waitIdle();

    // Push coinciding with a pop at level 2
    applyStimulus(8'h30, 8'hC0);
    applyStimulus(8'h31, 8'hC1);
    applyStimulus(8'h32, 8'hC2);
    n = 0;
    while (!(write_s[0] && addr_s[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("simul_data_seen", 32'(write_s[0] && addr_s[0]), 32'd1);
    repeat (DW) @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_simul_level_before", d), 32'(level_s[d]), 32'd2);
    applyStimulus(8'h33, 8'hC3);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_simul_level_same", d), 32'(level_s[d]), 32'd2);
    @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput($sformatf("d%0d_simul_level_hold", d), 32'(level_s[d]), 32'd2);
    waitIdle();

    // Reset while the first of three commands waits after its address write
    applyStimulus(8'h20, 8'h11);
    applyStimulus(8'h21, 8'h12);
    applyStimulus(8'h22, 8'h13);
    waitWrite(20, n);
    repeat (3) @(negedge clk);
    doReset();
    applyStimulus(8'h20, 8'h66);
    waitIdle();
    checkOutput("post_reset_addr_write", addr_count[0], 1);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      logic [7:0] r;
      cen_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       r = 8'h20;
        1:       r = 8'hA0;
        2:       r = 8'hB0;
        default: r = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(r, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) waitIdle();
    end
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
